conv_enc_213: RTL and testbench

CONV_ENC_213 -- requirements
Module: conv_enc_213

---
 rtl/conv_enc_213_pkg.sv | 23 ++
 rtl/enc_core_213.sv | 14 +
 rtl/conv_enc_213.sv | 98 +++++++++
 tb/tb_conv_enc_213.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_213_pkg.sv
// Shared (2,1,3) code parameters for the encoder and the matching Viterbi decoder:
// generators, memory/tail lengths, trellis size and encoder FSM encodings.
package conv_enc_213_pkg;

  localparam int MEM_LEN    = 3;
  localparam int TAIL_LEN   = 3;
  localparam int NUM_STATES = 1 << MEM_LEN;

  // Generator taps ordered {u, s0, s1, s2}: G0 = 17 octal, G1 = 15 octal
  localparam logic [3:0] G0 = 4'b1111;
  localparam logic [3:0] G1 = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } enc_state_e;

  function automatic logic gen_bit(input logic [3:0] g, input logic u, input logic [2:0] s);
    return ^(g & {u, s[0], s[1], s[2]});
  endfunction

endpackage

// File: rtl/enc_core_213.sv
// Combinational symbol generator: one input bit plus register state -> (c0, c1).
module enc_core_213
  import conv_enc_213_pkg::*;
(
  input  logic       u,
  input  logic [2:0] s,
  output logic       c0,
  output logic       c1
);

  assign c0 = gen_bit(G0, u, s);
  assign c1 = gen_bit(G1, u, s);

endmodule

// File: rtl/conv_enc_213.sv
// Rate-1/2, memory-3 feed-forward convolutional encoder with valid/ready streaming
// and an automatic 3-symbol zero tail that terminates every frame in state 000.
module conv_enc_213
  import conv_enc_213_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] out_sym,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [1:0] TAIL_END = 2'(TAIL_LEN - 1);

  enc_state_e state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [1:0] tail_q, tail_d;
  logic [1:0] out_sym_q, out_sym_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;

  logic slot, accept, tail_step, core_u, c0, c1;

  // During the tail the core sees u=0, so one generator serves both phases
  enc_core_213 u_core (
    .u  (core_u),
    .s  (s_q),
    .c0 (c0),
    .c1 (c1)
  );

  always_comb begin
    slot      = !out_valid_q || out_ready;
    in_ready  = (state_q != ST_FLUSH) && slot;
    accept    = in_valid && in_ready;
    tail_step = (state_q == ST_FLUSH) && slot;
    core_u    = accept && in_bit;

    state_d     = state_q;
    s_d         = s_q;
    tail_d      = tail_q;
    out_sym_d   = out_sym_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (slot) out_valid_d = 1'b0;

    if (accept) begin
      s_d         = {s_q[1:0], in_bit};
      out_sym_d   = {c0, c1};
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      tail_d      = 2'd0;
      state_d     = in_last ? ST_FLUSH : ST_DATA;
    end else if (tail_step) begin
      s_d         = {s_q[1:0], 1'b0};
      out_sym_d   = {c0, c1};
      out_valid_d = 1'b1;
      out_last_d  = (tail_q == TAIL_END);
      if (tail_q == TAIL_END) begin
        tail_d  = 2'd0;
        state_d = ST_IDLE;
      end else begin
        tail_d = tail_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      s_q         <= 3'b000;
      tail_q      <= 2'd0;
      out_sym_q   <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      tail_q      <= tail_d;
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_sym   = out_sym_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_conv_enc_213.sv
// Directed vector table plus model-checked sequences for the (2,1,3) encoder.
module tb_conv_enc_213;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, out_last, busy;
  logic [1:0] out_sym;

  int checks = 0;
  int failures = 0;

  conv_enc_213 dut (
    .clock(clock), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_sym(out_sym),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic iv, ib, il, ordy;
    logic exp_rdy;
    logic [1:0] exp_sym;
    logic exp_vld, exp_last, exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic       m_ov, m_last;
  logic [1:0] m_sym;
  logic [2:0] m_s;
  int         m_pend;
  logic       sent_q[$];
  int         flen_q[$];
  int         cur_len;
  logic [2:0] d_s;
  logic       dec_q[$];
  logic [1:0] cons_q[$];
  int         frames_done;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_last = 0; m_sym = 2'b00; m_s = 3'b000; m_pend = 0;
    sent_q.delete(); flen_q.delete(); cur_len = 0;
    d_s = 3'b000; dec_q.delete(); cons_q.delete();
  endtask

  function automatic logic [1:0] ref_sym(input logic u, input logic [2:0] s);
    logic a, b;
    a = u ^ s[0] ^ s[1] ^ s[2];
    b = u ^ s[0] ^ s[2];
    return {a, b};
  endfunction

  task automatic decode_frame_end();
    int n, errs;
    n = flen_q.size() > 0 ? flen_q.pop_front() : -1;
    errs = (dec_q.size() != n + 3) ? 1 : 0;
    if (errs == 0) begin
      for (int i = 0; i < n; i++) if (dec_q[i] != sent_q.pop_front()) errs++;
      for (int i = n; i < n + 3; i++) if (dec_q[i] != 1'b0) errs++;
    end
    chk("roundtrip_bit_errors", errs, 0);
    chk("decoder_end_state", int'(d_s), 0);
    dec_q.delete();
  endtask

  // One cycle driven and checked against the reference model
  task automatic step(input logic iv, input logic ib, input logic il, input logic ordy);
    logic slot, exp_rdy, acc, u;
    @(negedge clock);
    in_valid = iv; in_bit = ib; in_last = il; out_ready = ordy;
    #1;
    slot    = !m_ov || ordy;
    exp_rdy = (m_pend == 0) && slot;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("busy", busy, (m_pend != 0 || m_ov || cur_len != 0));
    if (m_ov) begin
      chk("out_sym", out_sym, m_sym);
      chk("out_last", out_last, m_last);
      if (ordy) begin
        cons_q.push_back(out_sym);
        u = out_sym[0] ^ d_s[0] ^ d_s[2];
        chk("c0_parity", out_sym[1], u ^ d_s[0] ^ d_s[1] ^ d_s[2]);
        dec_q.push_back(u);
        d_s = {d_s[1:0], u};
        if (out_last) decode_frame_end();
      end
    end
    acc = iv && exp_rdy;
    if (slot) m_ov = 0;
    if (acc) begin
      m_sym = ref_sym(ib, m_s); m_s = {m_s[1:0], ib};
      m_ov = 1; m_last = 0;
      sent_q.push_back(ib); cur_len++;
      if (il) begin
        m_pend = 3; flen_q.push_back(cur_len); cur_len = 0; frames_done++;
      end
    end else if (slot && m_pend > 0) begin
      m_sym = ref_sym(1'b0, m_s); m_s = {m_s[1:0], 1'b0};
      m_ov = 1; m_last = (m_pend == 1); m_pend--;
    end
    @(posedge clock);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_ov || m_pend != 0) && guard < 100) begin
      step(0, 0, 0, 1); guard++;
    end
    chk("drain_bounded", guard < 100, 1);
  endtask

  task automatic do_reset_check();
    @(negedge clock);
    reset = 0; in_valid = 0; out_ready = 0;
    @(posedge clock); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sym", out_sym, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clock);
    reset = 1;
    #1 chk("rst_in_ready", in_ready, 1);
    model_reset();
  endtask

  logic [9:0] bp_pat;
  logic [1:0] imp_exp[4];
  int cyc, rem;
  logic cur_bit, ordy_r, iv_r;

  initial begin
    model_reset();
    frames_done = 0;
    repeat (3) @(posedge clock);
    do_reset_check();

    // Impulse frame, all-zero 4-bit frame, back-to-back "1","1" (in_valid held in FLUSH)
    vecs.push_back('{1,1,1,1, 1, 2'b11, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b11, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b10, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b11, 1,1,1});
    vecs.push_back('{0,0,0,1, 1, 2'b00, 0,0,0});
    vecs.push_back('{1,0,0,1, 1, 2'b00, 1,0,1});
    vecs.push_back('{1,0,0,1, 1, 2'b00, 1,0,1});
    vecs.push_back('{1,0,0,1, 1, 2'b00, 1,0,1});
    vecs.push_back('{1,0,1,1, 1, 2'b00, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b00, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b00, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b00, 1,1,1});
    vecs.push_back('{0,0,0,1, 1, 2'b00, 0,0,0});
    vecs.push_back('{1,1,1,1, 1, 2'b11, 1,0,1});
    vecs.push_back('{1,1,1,1, 0, 2'b11, 1,0,1});
    vecs.push_back('{1,1,1,1, 0, 2'b10, 1,0,1});
    vecs.push_back('{1,1,1,1, 0, 2'b11, 1,1,1});
    vecs.push_back('{1,1,1,1, 1, 2'b11, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b11, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b10, 1,0,1});
    vecs.push_back('{0,0,0,1, 0, 2'b11, 1,1,1});
    vecs.push_back('{0,0,0,1, 1, 2'b00, 0,0,0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      in_valid = vecs[i].iv; in_bit = vecs[i].ib; in_last = vecs[i].il; out_ready = vecs[i].ordy;
      #1 chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
      @(posedge clock); #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_vld);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      if (vecs[i].exp_vld) begin
        chk($sformatf("v%0d_out_sym", i), out_sym, vecs[i].exp_sym);
        chk($sformatf("v%0d_out_last", i), out_last, vecs[i].exp_last);
      end
    end

    // Reset after one tail symbol has been taken; the pending one is discarded
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    do_reset_check();
    imp_exp[0] = 2'b11; imp_exp[1] = 2'b11; imp_exp[2] = 2'b10; imp_exp[3] = 2'b11;
    step(1, 1, 1, 1);
    drain();
    chk("post_rst_count", cons_q.size(), 4);
    for (int i = 0; i < 4 && i < cons_q.size(); i++)
      chk($sformatf("post_rst_sym%0d", i), cons_q[i], imp_exp[i]);

    // Back-pressure: 5 stalled cycles mid-frame with in_valid held high
    cons_q.delete();
    bp_pat = 10'b0111001101;
    for (int i = 0; i < 4; i++) step(1, bp_pat[i], 0, 1);
    for (int i = 0; i < 5; i++) step(1, bp_pat[4], 0, 0);
    for (int i = 4; i < 10; i++) step(1, bp_pat[i], i == 9, 1);
    drain();
    chk("bp_symbol_count", cons_q.size(), 13);
    chk("bp_frames_closed", flen_q.size(), 0);

    // Random frames with random back-pressure
    frames_done = 0; cyc = 0; rem = 0;
    while (frames_done < 1000 && cyc < 90000) begin
      if (rem == 0) rem = $urandom_range(1, 64);
      cur_bit = $urandom_range(0, 1);
      iv_r = ($urandom_range(0, 9) != 0);
      ordy_r = ($urandom_range(0, 4) != 0);
      begin
        int len_before = cur_len;
        int fd_before = frames_done;
        step(iv_r, cur_bit, rem == 1, ordy_r);
        if (cur_len != len_before || frames_done != fd_before) rem--;
      end
      cyc++;
    end
    chk("random_within_budget", cyc < 90000, 1);
    drain();
    chk("random_all_frames_decoded", flen_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
